// File: rtl/decoder_pkg.sv
// decoder_pkg: shared one-hot decode helper and select-width limit
package decoder_pkg;
  localparam int DEC_MAX_SEL_BITS = 8;
  localparam int DEC_MAX_OUT = 1 << DEC_MAX_SEL_BITS;
  typedef logic [DEC_MAX_SEL_BITS-1:0] dec_sel_t;
  typedef logic [DEC_MAX_OUT-1:0] dec_vec_t;
  function automatic dec_vec_t onehot_decode(input dec_sel_t sel);
    dec_vec_t v;
    v = '0;
    v[sel] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/decoder_if.sv
// decoder_if: select/enable inputs and decoded outputs of one decoder
interface decoder_if #(parameter int N_SEL_BITS = 1);
  localparam int N_OUT = 1 << N_SEL_BITS;
  logic [N_SEL_BITS-1:0] i_sel;
  logic i_en;
  logic [N_OUT-1:0] o;
  logic [N_OUT-1:0] o_q;
  logic o_q_vld;
  modport master (output i_sel, i_en, input o, o_q, o_q_vld);
  modport slave (input i_sel, i_en, output o, o_q, o_q_vld);
endinterface

// File: rtl/decoder.sv
// decoder: binary-to-one-hot decode with combinational and enable-gated registered outputs
module decoder
  import decoder_pkg::*;
#(
  parameter int N_SEL_BITS = 1
) (
  input logic i_clk,
  input logic i_rst,
  decoder_if.slave bus
);
  localparam int N_OUT = 1 << N_SEL_BITS;
  if (N_SEL_BITS < 1 || N_SEL_BITS > DEC_MAX_SEL_BITS) begin : g_chk
    $fatal(1, "decoder: N_SEL_BITS out of range 1..8");
  end
  logic [N_OUT-1:0] dec, dec_d, dec_q;
  logic vld_d, vld_q;
  always_comb begin
    dec = N_OUT'(onehot_decode(dec_sel_t'(bus.i_sel)));
    dec_d = i_rst ? '0 : bus.i_en ? dec : dec_q;
    vld_d = i_rst ? 1'b0 : bus.i_en ? 1'b1 : vld_q;
  end
  always_ff @(posedge i_clk) begin
    dec_q <= dec_d;
    vld_q <= vld_d;
  end
  assign bus.o = dec;
  assign bus.o_q = dec_q;
  assign bus.o_q_vld = vld_q;
endmodule

// File: tb/tb_decoder.sv
// tb_decoder: directed and randomised checks of decoder at N_SEL_BITS = 1, 2, 4
module tb_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] cnt = '0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  decoder_if #(.N_SEL_BITS(1)) if1 ();
  decoder_if #(.N_SEL_BITS(2)) if2 ();
  decoder_if #(.N_SEL_BITS(4)) if4 ();
  assign if1.i_sel = cnt[0];
  assign if2.i_sel = cnt[1:0];
  decoder #(.N_SEL_BITS(1)) u1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));
  decoder #(.N_SEL_BITS(2)) u2 (.i_clk(clk), .i_rst(rst), .bus(if2.slave));
  decoder #(.N_SEL_BITS(4)) u4 (.i_clk(clk), .i_rst(rst), .bus(if4.slave));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] m_q;
    logic m_vld;
    logic [3:0] s;
    logic e;
    if1.i_en = 1'b0;
    if2.i_en = 1'b0;
    if4.i_en = 1'b0;
    if4.i_sel = '0;
    cnt = 3'd0; #1 check("n1_sel0", if1.o, 32'b01);
    cnt = 3'd1; #1 check("n1_sel1", if1.o, 32'b10);
    cnt = 3'd0; #1 check("n2_sel0", if2.o, 32'b0001);
    check("n2_pop0", $countones(if2.o), 1);
    cnt = 3'd1; #1 check("n2_sel1", if2.o, 32'b0010);
    check("n2_pop1", $countones(if2.o), 1);
    cnt = 3'd2; #1 check("n2_sel2", if2.o, 32'b0100);
    check("n2_pop2", $countones(if2.o), 1);
    cnt = 3'd3; #1 check("n2_sel3", if2.o, 32'b1000);
    check("n2_pop3", $countones(if2.o), 1);
    for (int c = 0; c < 8; c++) begin
      cnt = 3'(c);
      #10;
      check("wrap_o1", if1.o, 32'(1) << (c % 2));
      check("wrap_o2", if2.o, 32'(1) << (c % 4));
      if (c == 5) begin
        check("sel5_o1", if1.o, 32'b10);
        check("sel5_o2", if2.o, 32'b0010);
      end
      if (c == 6) begin
        check("sel6_o1", if1.o, 32'b01);
        check("sel6_o2", if2.o, 32'b0100);
      end
    end
    rst = 1'b1;
    tick();
    tick();
    check("rst_oq", if2.o_q, 32'b0000);
    check("rst_vld", if2.o_q_vld, 32'd0);
    rst = 1'b0;
    if2.i_en = 1'b1;
    cnt = 3'd2;
    tick();
    check("load_oq", if2.o_q, 32'b0100);
    check("load_vld", if2.o_q_vld, 32'd1);
    if2.i_en = 1'b0;
    cnt = 3'd3;
    tick();
    check("hold_oq", if2.o_q, 32'b0100);
    check("hold_vld", if2.o_q_vld, 32'd1);
    check("hold_o", if2.o, 32'b1000);
    rst = 1'b1;
    if2.i_en = 1'b1;
    cnt = 3'd1;
    tick();
    check("prio_oq", if2.o_q, 32'b0000);
    check("prio_vld", if2.o_q_vld, 32'd0);
    check("prio_o", if2.o, 32'b0010);
    rst = 1'b0;
    tick();
    check("rel_oq", if2.o_q, 32'b0010);
    check("rel_vld", if2.o_q_vld, 32'd1);
    if2.i_en = 1'b0;
    check("n4_rst_oq", if4.o_q, 32'd0);
    check("n4_rst_vld", if4.o_q_vld, 32'd0);
    m_q = '0;
    m_vld = 1'b0;
    for (int i = 0; i < 200; i++) begin
      s = 4'($urandom_range(0, 15));
      e = 1'($urandom_range(0, 1));
      if4.i_sel = s;
      if4.i_en = e;
      #1 check("rnd_o", if4.o, 32'(1) << s);
      tick();
      if (e) begin
        m_q = 16'(1) << s;
        m_vld = 1'b1;
      end
      check("rnd_oq", if4.o_q, m_q);
      check("rnd_vld", if4.o_q_vld, m_vld);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decoder.md
Name: decoder

Overview:
- Parameterised binary-to-one-hot decoder.
- An N_SEL_BITS-wide select drives a 2**N_SEL_BITS-wide output with exactly one bit high, at the index equal to the select value.
- Provides a purely combinational output (o) and a registered, enable-gated copy (o_q) for timing-critical consumers.
- Used as a generic leaf utility, e.g. register-file write-enable and mux-select generation.

Parameters:
- N_SEL_BITS, default 1: select width. Legal range 1..8. Output width is N_OUT = 2**N_SEL_BITS, a derived localparam that is not overridable.

Ports:
- i_clk, input, 1: clock, rising-edge active. Used only by the registered path.
- i_rst, input, 1: reset, synchronous and active-high.
- i_sel, input, N_SEL_BITS: binary select value.
- i_en, input, 1: load enable for the registered output.
- o, output, N_OUT: combinational one-hot decode of i_sel.
- o_q, output, N_OUT: registered one-hot decode.
- o_q_vld, output, 1: high once o_q holds a loaded decode.

Behaviour:
- Combinational path, o:
  - o[k] = 1 iff i_sel == k, for k in 0..N_OUT-1. All other bits are 0.
  - Zero latency. Output follows i_sel within the same delta/cycle.
  - Does not depend on i_clk, i_rst or i_en.
  - Every i_sel value is in range, so o is always exactly one-hot (popcount 1), including during reset.
  - X or Z on i_sel may propagate X to o. No X-masking is required.
- Registered path, on each rising edge of i_clk:
  - If i_rst = 1: o_q <= 0 (all bits), o_q_vld <= 0. Reset has priority over i_en.
  - Else if i_en = 1: o_q <= decode(i_sel), o_q_vld <= 1.
  - Else: o_q and o_q_vld hold their values.
- Registered-path latency is 1 cycle from i_sel/i_en sampled at the edge.
- Reset values: o_q = 0 (not one-hot; o_q_vld = 0 flags this), o_q_vld = 0. There is no reset value for o, since it is combinational.
- Reset mid-operation clears o_q on the next edge regardless of i_en. The first load after reset deasserts requires i_en = 1.
- Invariant: o_q_vld = 1 implies o_q is one-hot. o_q_vld = 0 implies o_q = 0.
- Width rule: select bits above N_SEL_BITS do not exist inside the block. Callers that slice a wider bus get decode of the low bits only (wrap-around modulo N_OUT).
- Elaboration check: N_SEL_BITS < 1 or > 8 is a fatal elaboration error.
- Implementation: the decode is a shift or per-bit compare in a single function shared by both paths. No latches. A single always_ff block.

Decomposition:
- A shared utility package holds:
  - function onehot_decode(sel) returning a one-hot vector;
  - constant DEC_MAX_SEL_BITS = 8.
- No sub-module. The block is a single leaf module.
- An optional encoder counterpart (one-hot to binary) lives separately, not inside this block.

Test Plan:
- N_SEL_BITS=1, i_sel = 0 then 1 -> o = 2'b01 then 2'b10.
- N_SEL_BITS=2, sweep i_sel 0..3 -> o = 0001, 0010, 0100, 1000. Assert popcount(o) = 1 at every step.
- Two instances, N=1 fed sel[0] and N=2 fed sel[1:0], driven from a 3-bit counter 0..7 every 10 ns:
  - At sel = 5: o1 = 10, o2 = 0010.
  - At sel = 6: o1 = 01, o2 = 0100.
  - This checks wrap-around via slicing.
- Registered path, N=2: i_rst = 1 for 2 cycles -> o_q = 0000, o_q_vld = 0. Then i_en = 1, i_sel = 2 -> next edge o_q = 0100, o_q_vld = 1. Then i_en = 0, i_sel = 3 -> o_q stays 0100 while o = 1000.
- Reset priority: i_rst = 1 and i_en = 1 with i_sel = 1 on the same edge -> o_q = 0000, o_q_vld = 0. Release reset with i_en = 1 -> o_q = 0010 one cycle later.
- Randomised N_SEL_BITS=4, 200 cycles: o == (1 << i_sel) always, and o_q equals the decode of i_sel from the last edge with i_en = 1.
